enc83_arb: RTL and testbench
============================

ENC83_ARB -- requirements
Module: enc83_arb

Interface
REQ-001 Parameter: PRIO_HIGH, default 1, 1 = highest pending index wins, 0 = lowest pending index wins.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  request capture enable; 0 = req ignored.
REQ-005 req  input  8  one-bit-per-source request lines, multi-hot allowed.
REQ-006 out_ready  input  1  consumer accepts out_code this cycle.
REQ-007 out_valid  output  1  out_code holds a valid encoded index.
REQ-008 out_code  output  3  binary index of granted source.
REQ-009 pending  output  8  registered sticky request vector.
REQ-010 pend_cnt  output  4  population count of pending, range 0..8.
REQ-011 overflow  output  1  one-cycle pulse: request hit an already-pending bit.

Function
REQ-012 Block SHALL encode one-hot/multi-hot requests back to 3-bit indices, one index per handshake.
REQ-013 Capture: at each edge, pending SHALL become (pending & ~clr) | (en ? req : 8'h00); clr = onehot(out_code) when out_valid & out_ready, else 0.
REQ-014 Set-wins: bit being cleared by handshake and re-requested in same cycle SHALL remain set; no overflow.
REQ-015 overflow SHALL be registered, high for exactly the cycle after any en & req[i] & pending[i] & ~clr[i]; else 0.
REQ-016 pend_cnt SHALL be a combinational popcount of the pending register (no added latency).
REQ-017 FSM states: IDLE, OFFER; out_valid SHALL be 1 exactly in OFFER.
REQ-018 IDLE -> OFFER at edge where pending register nonzero; out_code loaded with selected index (per PRIO_HIGH) of pending at that edge.
REQ-019 IDLE stays IDLE while pending == 0; out_code holds last value.
REQ-020 OFFER with out_ready = 0: SHALL hold state; out_code and out_valid stable (no re-arbitration even if higher-priority bit arrives).
REQ-021 OFFER with out_ready = 1: handshake; SHALL go to IDLE (one bubble cycle, out_valid = 0), then re-arbitrate.
REQ-022 Latency: req at cycle N (en = 1, idle, pending = 0) -> pending set after edge N+1 -> out_valid = 1 after edge N+2.
REQ-023 en = 0 SHALL NOT stop draining; already pending bits continue to be offered until empty.
REQ-024 out_ready while out_valid = 0 SHALL have no effect.
REQ-025 Throughput: at most one grant per two cycles; 8 simultaneous requests drain in 16 cycles after first offer edge.

Reset
REQ-026 rst_n low SHALL immediately (no clock) force: state IDLE, out_valid 0, out_code 3'd0, pending 8'h00, overflow 0 (pend_cnt thus 0).
REQ-027 Reset mid-OFFER SHALL discard the outstanding grant and all pending requests; no grant completes.
REQ-028 Deassertion of rst_n SHALL take effect at next rising edge; req sampled from that edge onward.

Verification
REQ-029 Single: en=1, req=8'h20 one cycle, out_ready=1 -> out_valid=1 two edges later, out_code=3'd5, pending=8'h00 after handshake.
REQ-030 Priority drain: req=8'h81 once, PRIO_HIGH=1, out_ready=1 -> grants 7 then 0, bubble between, pend_cnt 2->1->0.
REQ-031 Stall: req=8'h04 then 8'h40 while out_ready=0 -> out_code stays 3'd2 until ready; then 3'd6 granted next.
REQ-032 Overflow/set-wins: pending=8'h08, req=8'h08 without handshake -> overflow pulse 1 cycle; same req during handshake of code 3 -> no pulse, bit 3 re-offered.
REQ-033 en=0: pending=8'h11, en=0, req=8'hFF -> only codes 4 and 0 granted, no overflow, pend_cnt ends 0.
REQ-034 Async reset: rst_n low mid-OFFER between edges -> out_valid, pending, pend_cnt read 0 immediately; req=8'hFF on reset held ignored.

Source files
------------

// File: rtl/enc83_arb.sv
// Sticky request capture with a two-state offer/handshake encoder: pending
// requests are granted one index at a time, highest or lowest index first.
module enc83_arb #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic [7:0] pending,
    output logic [3:0] pend_cnt,
    output logic       overflow
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t     state, state_nx;
    logic [2:0] code_r, code_nx;
    logic [7:0] pend_r, pend_nx;
    logic [7:0] clr, cap;
    logic       ovf_r, ovf_nx;

    function automatic logic [2:0] pick(input logic [7:0] v);
        logic [2:0] idx;
        logic       found;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                // Ascending scan: the last hit is the highest index, the first hit the lowest.
                if (PRIO_HIGH || !found) idx = i[2:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, v[i]};
        return cnt;
    endfunction

    always_comb begin
        clr      = 8'h00;
        cap      = en ? req : 8'h00;
        state_nx = state;
        code_nx  = code_r;
        if (state == OFFER && out_ready) clr = 8'h01 << code_r;
        // A bit re-requested while its grant completes stays set (set wins).
        pend_nx  = (pend_r & ~clr) | cap;
        ovf_nx   = |(cap & pend_r & ~clr);
        case (state)
            IDLE: begin
                if (pend_r != 8'h00) begin
                    state_nx = OFFER;
                    code_nx  = pick(pend_r);
                end
            end
            OFFER: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            code_r <= 3'd0;
            pend_r <= 8'h00;
            ovf_r  <= 1'b0;
        end else begin
            state  <= state_nx;
            code_r <= code_nx;
            pend_r <= pend_nx;
            ovf_r  <= ovf_nx;
        end
    end

    assign out_valid = (state == OFFER);
    assign out_code  = code_r;
    assign pending   = pend_r;
    assign pend_cnt  = popcount(pend_r);
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_enc83_arb.sv
// Bench for enc83_arb: directed scenarios plus random traffic against a
// set-based reference model; grants are checked by a queue-driven monitor.
module tb_enc83_arb;

    localparam bit PH = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [2:0] out_code;
    logic [7:0] pending;
    logic [3:0] pend_cnt;
    logic       overflow;

    enc83_arb #(.PRIO_HIGH(PH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
        .out_valid(out_valid), .out_code(out_code), .pending(pending),
        .pend_cnt(pend_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: set of pending sources, index being offered (-1 = none).
    bit [7:0] m_pend = 8'h00;
    int       m_offer = -1;
    int       m_code = 0;
    bit       m_ovf = 1'b0;
    int       exp_q[$];

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int model_pick(input bit [7:0] v);
        int idx[$];
        for (int i = 0; i < 8; i++) if (v[i]) idx.push_back(i);
        return PH ? idx[idx.size()-1] : idx[0];
    endfunction

    function automatic int count_set(input bit [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += v[i];
        return n;
    endfunction

    // One clock cycle: check outputs against the model, apply inputs, advance model.
    task automatic step(input bit e, input bit [7:0] r, input bit rd);
        bit [7:0] done, fresh, n_pend;
        int       n_offer, n_code;
        bit       n_ovf;
        @(negedge clk);
        chk("out_valid", out_valid, (m_offer >= 0) ? 1 : 0);
        chk("out_code",  out_code, m_code);
        chk("pending",   pending, m_pend);
        chk("pend_cnt",  pend_cnt, count_set(m_pend));
        chk("overflow",  overflow, m_ovf);
        en = e; req = r; out_ready = rd;
        done    = (m_offer >= 0 && rd) ? (8'h01 << m_offer) : 8'h00;
        fresh   = e ? r : 8'h00;
        n_pend  = (m_pend & ~done) | fresh;
        n_ovf   = |(fresh & m_pend & ~done);
        n_offer = m_offer;
        n_code  = m_code;
        if (m_offer < 0) begin
            if (m_pend != 0) begin
                n_offer = model_pick(m_pend);
                n_code  = n_offer;
                exp_q.push_back(n_offer);
            end
        end else if (rd) begin
            n_offer = -1;
        end
        @(posedge clk);
        m_pend = n_pend; m_offer = n_offer; m_code = n_code; m_ovf = n_ovf;
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        #3;
        rst_n = 1'b0; en = 1'b1; req = 8'hFF; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pending",   pending, 0);
        chk("rst_pend_cnt",  pend_cnt, 0);
        chk("rst_overflow",  overflow, 0);
        chk("rst_out_code",  out_code, 0);
        m_pend = 8'h00; m_offer = -1; m_code = 0; m_ovf = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_pending", pending, 0);
        chk("rst_hold_valid",   out_valid, 0);
        rst_n = 1'b1; en = 1'b0; req = 8'h00; out_ready = 1'b0;
    endtask

    // Grant monitor: decoupled from stimulus, pops one expected index per handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("grant_unexpected", out_code, -1);
                else chk("grant_code", out_code, exp_q.pop_front());
            end
        end
    end

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("init_out_valid", out_valid, 0);
        chk("init_pending",   pending, 0);
        chk("init_pend_cnt",  pend_cnt, 0);
        chk("init_out_code",  out_code, 0);
        rst_n = 1'b1;

        // Single request of source 5.
        step(1, 8'h20, 1);
        repeat (5) step(0, 8'h00, 1);

        // Two sources drained high first, with a bubble between grants.
        step(1, 8'h81, 1);
        repeat (7) step(0, 8'h00, 1);

        // Stall: higher source arriving during an offer waits its turn.
        step(1, 8'h04, 0);
        step(1, 8'h40, 0);
        repeat (3) step(0, 8'h00, 0);
        repeat (6) step(0, 8'h00, 1);

        // Overflow on re-request, then set-wins during handshake of code 3.
        step(1, 8'h08, 0);
        step(1, 8'h08, 0);
        guard = 0;
        while (m_offer != 3 && guard < 20) begin
            step(0, 8'h00, 0);
            guard++;
        end
        chk("wait_offer3_timeout", (guard < 20) ? 1 : 0, 1);
        step(1, 8'h08, 1);
        repeat (6) step(0, 8'h00, 1);

        // Disabled capture still drains what is already pending.
        step(1, 8'h11, 0);
        repeat (10) step(0, 8'hFF, 1);

        // All eight sources at once.
        step(1, 8'hFF, 1);
        repeat (20) step(0, 8'h00, 1);

        // Asynchronous reset while an offer is outstanding.
        repeat (3) step(1, 8'hFF, 0);
        do_reset_mid();
        step(1, 8'h02, 1);
        repeat (4) step(0, 8'h00, 1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            bit [7:0] r;
            r = 8'($urandom) & 8'($urandom) & 8'($urandom);
            step(($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 1)));
        end
        repeat (20) step(0, 8'h00, 1);
        chk("queue_empty_at_end", exp_q.size(), 0);

        @(negedge clk);
        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
